// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings and the request error check for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;
  function automatic logic lsu_err(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] words);
    return size == 2'b11 || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00) ||
           {2'b00, addr[31:2]} >= words;
  endfunction
endpackage

// File: rtl/lsu_lane_merge.sv
// lsu_lane_merge: little-endian lane insert for sub-word stores and lane extract/extend for loads
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  output logic [31:0] merged,
  output logic [31:0] loaded
);
  logic [4:0]  off;
  logic [31:0] sh;
  logic [31:0] mask;
  // bit offset of the addressed lane, then insert and extract around it
  always_comb begin
    off    = size == SZ_HALF ? {lane[1], 4'b0000} : {lane, 3'b000};
    sh     = word >> off;
    mask   = (size == SZ_BYTE ? 32'h0000_00FF : size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << off;
    merged = (word & ~mask) | ((data << off) & mask);
    loaded = size == SZ_BYTE ? {{24{!uns && sh[7]}}, sh[7:0]} :
             size == SZ_HALF ? {{16{!uns && sh[15]}}, sh[15:0]} : word;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte/half/word load-store sequencer over a word-wide memory using read-modify-write
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);
  state_t      state;
  logic [31:0] a;
  logic [31:0] d;
  logic [31:0] wword;
  logic        st;
  logic        u;
  logic [1:0]  sz;
  logic [31:0] merged;
  logic [31:0] loaded;
  logic        e_in;
  lsu_lane_merge u_merge (
    .word  (mem_rdata),
    .data  (d),
    .size  (sz),
    .lane  (a[1:0]),
    .uns   (u),
    .merged(merged),
    .loaded(loaded)
  );
  assign e_in       = lsu_err(req_addr, req_size, 32'(MEM_WORDS));
  assign req_ready  = state == IDLE && !reset;
  assign resp_valid = state == RESP;
  assign mem_we     = state == WRITE && !reset;
  assign mem_addr   = (state == READ || state == WRITE) ? {2'b00, a[31:2]} : 32'h0;
  assign mem_wdata  = mem_we ? wword : 32'h0;
  // request latch, memory sequencing and held response
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      a          <= '0;
      d          <= '0;
      wword      <= '0;
      st         <= 1'b0;
      u          <= 1'b0;
      sz         <= SZ_BYTE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a          <= req_addr;
          d          <= req_wdata;
          st         <= req_store;
          sz         <= req_size;
          u          <= req_unsigned;
          wword      <= req_wdata;
          resp_rdata <= '0;
          resp_err   <= e_in;
          state      <= e_in ? RESP : (req_store && req_size == SZ_WORD) ? WRITE : READ;
        end
        READ: begin
          wword      <= merged;
          resp_rdata <= st ? 32'h0 : loaded;
          state      <= st ? WRITE : RESP;
        end
        WRITE: state <= RESP;
        RESP: if (resp_ready) begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
